// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_reader_pkg
//  Description : Shared constants and FSM state type for the FIFO reader.
//                C_DATA_W_DEFAULT - default data width
//                C_SKID_DEPTH     - output buffer entries (fixed at 2)
//                C_WORD_CNT_W     - width of the optional handshake counter
//                state_t          - reader FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_reader_pkg;

    localparam int C_DATA_W_DEFAULT = 8;
    localparam int C_SKID_DEPTH     = 2;
    localparam int C_WORD_CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        SINGLE = 2'd2,
        WAIT   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_reader_if
//  Description : FIFO-side and downstream-side signals of the FIFO reader.
//                fifo_data/fifo_ef/fifo_aef/fifo_vf/fifo_uf : from the FIFO
//                fifo_rd_en                                 : pop to the FIFO
//                dout/dout_vld                              : to downstream
//                dout_rdy                                   : from downstream
//                master modport = reader side, slave = FIFO + sink side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_reader_if
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = C_DATA_W_DEFAULT
) ();

    logic [DATA_W-1:0] fifo_data;
    logic              fifo_ef;
    logic              fifo_aef;
    logic              fifo_vf;
    logic              fifo_uf;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic              dout_rdy;

    modport master (
        input  fifo_data, fifo_ef, fifo_aef, fifo_vf, fifo_uf, dout_rdy,
        output fifo_rd_en, dout, dout_vld
    );

    modport slave (
        output fifo_data, fifo_ef, fifo_aef, fifo_vf, fifo_uf, dout_rdy,
        input  fifo_rd_en, dout, dout_vld
    );

endinterface
`default_nettype wire

// File: rtl/fifo_reader_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_reader_skid
//  Description : Small circular output buffer for the FIFO reader.
//                i_push/i_push_data : write one word
//                i_pop              : remove the head word
//                o_dout/o_dout_vld  : head word and its valid flag
//                o_occupancy        : number of words held
//                The head is read straight from storage, so it cannot change
//                while no pop happens.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W     = C_DATA_W_DEFAULT,
    parameter int SKID_DEPTH = C_SKID_DEPTH
) (
    input  wire logic                                 clk,
    input  wire logic                                 rst_n,
    input  wire logic                                 i_push,
    input  wire logic [DATA_W-1:0]                    i_push_data,
    input  wire logic                                 i_pop,
    output logic      [DATA_W-1:0]                    o_dout,
    output logic                                      o_dout_vld,
    output logic      [$clog2(SKID_DEPTH + 1)-1:0]    o_occupancy
);

    localparam int C_OCC_W = $clog2(SKID_DEPTH + 1);
    // Pointers wrap by natural overflow; depth is a power of two (2).
    localparam int C_PTR_W = $clog2(SKID_DEPTH);

    logic [DATA_W-1:0]  r_mem [SKID_DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_OCC_W-1:0] r_occ;
    logic               w_pop;
    logic               w_push;

    assign w_pop  = i_pop && (r_occ != '0);
    // A push into a full buffer is only legal when the head leaves that cycle.
    assign w_push = i_push && ((r_occ != C_OCC_W'(SKID_DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + C_OCC_W'(1);
                2'b01:   r_occ <= r_occ - C_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_dout      = r_mem[r_rd_ptr];
    assign o_dout_vld  = (r_occ != '0);
    assign o_occupancy = r_occ;

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_reader
//  Description : Pulls words from a latency-1 FIFO into a 2-entry output
//                buffer and presents them on a valid/ready interface.
//                clk      : rising-edge clock
//                rst_n    : asynchronous active-low reset
//                enable   : permits new reads
//                bus      : fifo_reader_if.master (FIFO + downstream signals)
//                err      : sticky error (underflow or unexpected valid)
//                word_cnt : downstream handshake count, present only when
//                           FIFO_READER_STATS_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W     = C_DATA_W_DEFAULT,
    parameter int SKID_DEPTH = C_SKID_DEPTH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             enable,
    fifo_reader_if.master         bus,
    output logic                  err
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [C_WORD_CNT_W-1:0] word_cnt
`endif
);

    localparam int C_OCC_W = $clog2(SKID_DEPTH + 1);

    state_t             r_state;
    logic               r_inflight;
    logic               r_vf_mask;
    logic               r_err;
    logic               w_push;
    logic               w_pop;
    logic               w_credit;
    logic               w_rd_en;
    logic [C_OCC_W-1:0] w_occ;
    logic [C_OCC_W:0]   w_committed;
    logic [DATA_W-1:0]  w_dout;
    logic               w_dout_vld;

    // Only a word we actually asked for is captured.
    assign w_push = bus.fifo_vf && r_inflight;
    assign w_pop  = w_dout_vld && bus.dout_rdy;

    // Words that will sit in the buffer after this edge. A new read issued
    // now lands one cycle later, so it is safe only while this stays below
    // the buffer depth; counting this cycle's pop keeps STREAM at full rate.
    assign w_committed = {1'b0, w_occ} + (C_OCC_W + 1)'(r_inflight)
                       - (C_OCC_W + 1)'(w_pop);
    assign w_credit    = (w_committed < (C_OCC_W + 1)'(SKID_DEPTH));

    // Read issue is a decode of the registered state; it deliberately does
    // not look at enable so a read already under way in STREAM completes.
    // STREAM stops at almost-empty so the last word goes through SINGLE.
    always_comb begin
        w_rd_en = 1'b0;
        case (r_state)
            STREAM:  w_rd_en = w_credit && !bus.fifo_ef && !bus.fifo_aef;
            SINGLE:  w_rd_en = w_credit && !bus.fifo_ef;
            default: w_rd_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_inflight <= 1'b0;
            r_vf_mask  <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            // Until the first read after reset, a valid strobe is the echo of
            // a read discarded by the reset and is not an error.
            if (w_rd_en) begin
                r_vf_mask <= 1'b0;
            end
            if (bus.fifo_uf || (bus.fifo_vf && !r_inflight && !r_vf_mask)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (enable && !bus.fifo_ef) begin
                        r_state <= bus.fifo_aef ? SINGLE : STREAM;
                    end
                end
                STREAM: begin
                    if (!enable || bus.fifo_ef) begin
                        r_state <= IDLE;
                    end else if (bus.fifo_aef) begin
                        r_state <= SINGLE;
                    end
                end
                SINGLE: begin
                    if (w_rd_en) begin
                        r_state <= WAIT;
                    end else if (bus.fifo_ef) begin
                        r_state <= IDLE;
                    end
                end
                // One idle cycle so the FIFO flags catch up with the pop.
                WAIT:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    fifo_reader_skid #(
        .DATA_W     (DATA_W),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (bus.fifo_data),
        .i_pop       (w_pop),
        .o_dout      (w_dout),
        .o_dout_vld  (w_dout_vld),
        .o_occupancy (w_occ)
    );

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.dout       = w_dout;
    assign bus.dout_vld   = w_dout_vld;
    assign err            = r_err;

`ifdef FIFO_READER_STATS_EN
    logic [C_WORD_CNT_W-1:0] r_word_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + C_WORD_CNT_W'(1);
        end
    end

    assign word_cnt = r_word_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_reader
//  Description : Directed self-checking bench for fifo_reader. A behavioural
//                latency-1 FIFO feeds the reader; a negedge monitor records
//                downstream handshakes and read pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_reader
    import fifo_reader_pkg::*;
;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic rdy;
    logic inj_uf;
    logic inj_vf;
    logic err;
`ifdef FIFO_READER_STATS_EN
    logic [15:0] word_cnt;
`endif

    // FIFO model state
    logic [7:0] fq[$];
    logic [7:0] m_data = 8'h00;
    logic       m_vf   = 1'b0;
    logic       m_uf   = 1'b0;
    logic       m_ef   = 1'b1;
    logic       m_aef  = 1'b1;

    // Monitor state
    logic [7:0] rx[$];
    int         rx_cyc[$];
    int         n_rd    = 0;
    int         cyc_cnt = 0;

    int n_assert = 0;
    int n_fail   = 0;
    int rx_base;
    int rd_base;

    fifo_reader_if #(.DATA_W(8)) bus ();

    assign bus.fifo_data = m_data;
    assign bus.fifo_ef   = m_ef;
    assign bus.fifo_aef  = m_aef;
    assign bus.fifo_vf   = m_vf | inj_vf;
    assign bus.fifo_uf   = m_uf | inj_uf;
    assign bus.dout_rdy  = rdy;

    fifo_reader #(
        .DATA_W     (8),
        .SKID_DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (bus),
        .err      (err)
`ifdef FIFO_READER_STATS_EN
        ,
        .word_cnt (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Latency-1 FIFO: flags reflect the contents after this edge's pop.
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            if (fq.size() > 0) begin
                m_data <= fq.pop_front();
                m_vf   <= 1'b1;
                m_uf   <= 1'b0;
            end else begin
                m_vf <= 1'b0;
                m_uf <= 1'b1;
            end
        end else begin
            m_vf <= 1'b0;
            m_uf <= 1'b0;
        end
        m_ef  <= (fq.size() == 0);
        m_aef <= (fq.size() <= 1);
    end

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (bus.dout_vld && bus.dout_rdy) begin
            rx.push_back(bus.dout);
            rx_cyc.push_back(cyc_cnt);
        end
        if (bus.fifo_rd_en) begin
            n_rd <= n_rd + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k = 0;
        while ((rx.size() < n) && (k < budget)) begin
            cyc(1);
            k++;
        end
        check(tag, 32'(rx.size() >= n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        rdy    = 1'b0;
        inj_uf = 1'b0;
        inj_vf = 1'b0;
        cyc(3);
        check("rst_dout_vld", 32'(bus.dout_vld), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // ---- A: 32 words, full-rate stream then single/wait at the tail
        for (int i = 1; i <= 32; i++) fq.push_back(8'(i));
        cyc(2);
        rx_base = rx.size();
        rd_base = n_rd;
        rdy     = 1'b1;
        enable  = 1'b1;
        wait_rx(rx_base + 32, 200, "A_timeout");
        cyc(6);
        check("A_count", 32'(rx.size() - rx_base), 32'd32);
        for (int i = 0; i < 32; i++) begin
            if (rx_base + i < rx.size()) check("A_order", 32'(rx[rx_base + i]), 32'(i + 1));
        end
        if (rx.size() >= rx_base + 32) begin
            check("A_stream_span", 32'(rx_cyc[rx_base + 30] - rx_cyc[rx_base]), 32'd30);
            check("A_tail_gap", 32'(rx_cyc[rx_base + 31] - rx_cyc[rx_base + 30]), 32'd2);
        end
        check("A_reads", 32'(n_rd - rd_base), 32'd32);
        check("A_err", 32'(err), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("A_word_cnt", 32'(word_cnt), 32'd32);
`endif

        // ---- B: downstream stall of 10 cycles mid-stream
        enable = 1'b0;
        cyc(1);
        for (int i = 0; i < 20; i++) fq.push_back(8'(33 + i));
        cyc(2);
        rx_base = rx.size();
        rd_base = n_rd;
        enable  = 1'b1;
        cyc(5);
        rdy = 1'b0;
        check("B_stall_vld", 32'(bus.dout_vld), 32'd1);
        check("B_stall_head", 32'(bus.dout), 32'd35);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("B_stable", 32'(bus.dout), 32'd35);
        end
        check("B_stable_vld", 32'(bus.dout_vld), 32'd1);
        check("B_reads_stalled", 32'(n_rd - rd_base), 32'd4);
        check("B_rd_en_low", 32'(bus.fifo_rd_en), 32'd0);
        rdy = 1'b1;
        wait_rx(rx_base + 20, 200, "B_timeout");
        cyc(8);
        check("B_count", 32'(rx.size() - rx_base), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (rx_base + i < rx.size()) check("B_order", 32'(rx[rx_base + i]), 32'(33 + i));
        end
        check("B_reads", 32'(n_rd - rd_base), 32'd20);
        check("B_err", 32'(err), 32'd0);

        // ---- C: one word in the FIFO -> SINGLE, WAIT, IDLE
        enable = 1'b0;
        cyc(2);
        fq.push_back(8'hA5);
        cyc(2);
        rx_base = rx.size();
        rd_base = n_rd;
        enable  = 1'b1;
        cyc(1);
        check("C_state_single", 32'(dut.r_state), 32'(SINGLE));
        check("C_rd_en_single", 32'(bus.fifo_rd_en), 32'd1);
        cyc(1);
        check("C_state_wait", 32'(dut.r_state), 32'(WAIT));
        check("C_rd_en_wait", 32'(bus.fifo_rd_en), 32'd0);
        cyc(1);
        check("C_state_idle", 32'(dut.r_state), 32'(IDLE));
        cyc(8);
        check("C_reads", 32'(n_rd - rd_base), 32'd1);
        check("C_count", 32'(rx.size() - rx_base), 32'd1);
        if (rx.size() > rx_base) check("C_word", 32'(rx[rx_base]), 32'hA5);

        // ---- D: enable drops in the cycle a read is issued
        enable = 1'b0;
        cyc(2);
        for (int i = 0; i < 10; i++) fq.push_back(8'(8'h60 + i));
        cyc(2);
        rx_base = rx.size();
        rd_base = n_rd;
        enable  = 1'b1;
        cyc(1);
        enable = 1'b0;
        check("D_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        cyc(8);
        check("D_reads", 32'(n_rd - rd_base), 32'd1);
        check("D_count", 32'(rx.size() - rx_base), 32'd1);
        if (rx.size() > rx_base) check("D_word", 32'(rx[rx_base]), 32'h60);

        // ---- E: reset while two words are buffered
        rx_base = rx.size();
        rd_base = n_rd;
        rdy     = 1'b0;
        enable  = 1'b1;
        cyc(8);
        check("E_full_vld", 32'(bus.dout_vld), 32'd1);
        check("E_full_head", 32'(bus.dout), 32'h61);
        rst_n = 1'b0;
        #1;
        check("E_rst_vld", 32'(bus.dout_vld), 32'd0);
        check("E_rst_dout", 32'(bus.dout), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        rdy   = 1'b1;
        wait_rx(rx_base + 7, 200, "E_timeout");
        cyc(8);
        if (rx.size() > rx_base) check("E_first", 32'(rx[rx_base]), 32'h63);
        check("E_count", 32'(rx.size() - rx_base), 32'd7);
        check("E_reads", 32'(n_rd - rd_base), 32'd9);
        check("E_err", 32'(err), 32'd0);

        // ---- F: stray valid after reset, stray valid later, underflow
        enable = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        inj_vf = 1'b1;
        cyc(1);
        inj_vf = 1'b0;
        cyc(1);
        check("F_post_rst_vf_err", 32'(err), 32'd0);
        check("F_post_rst_vf_vld", 32'(bus.dout_vld), 32'd0);
        fq.push_back(8'h77);
        cyc(2);
        rx_base = rx.size();
        enable  = 1'b1;
        wait_rx(rx_base + 1, 50, "F_timeout");
        cyc(4);
        enable = 1'b0;
        if (rx.size() > rx_base) check("F_word", 32'(rx[rx_base]), 32'h77);
        cyc(2);
        check("F_err_before_vf", 32'(err), 32'd0);
        inj_vf = 1'b1;
        cyc(1);
        inj_vf = 1'b0;
        cyc(1);
        check("F_stray_vf_err", 32'(err), 32'd1);
        rst_n = 1'b0;
        #1;
        check("F_rst_clears_err", 32'(err), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        inj_uf = 1'b1;
        cyc(1);
        inj_uf = 1'b0;
        cyc(1);
        check("F_uf_err", 32'(err), 32'd1);
        cyc(5);
        check("F_uf_sticky", 32'(err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width matching the FIFO data port.
REQ-002 SHALL have parameter SKID_DEPTH, fixed at 2: output buffer entries.
REQ-003 SHALL have port CLK  in  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ENABLE  in  1  high: the block may issue reads.
REQ-006 SHALL have port FIFO_DATA  in  DATA_W  FIFO read data.
REQ-007 SHALL have port FIFO_EF / FIFO_AEF / FIFO_VF / FIFO_UF  in  1 each  FIFO empty, almost-empty, read-valid and underflow flags.
REQ-008 SHALL have port FIFO_RD_EN  out  1  FIFO pop request.
REQ-009 SHALL have port DOUT  out  DATA_W  downstream data.
REQ-010 SHALL have port DOUT_VLD  out  1  DOUT holds a valid word.
REQ-011 SHALL have port DOUT_RDY  in  1  downstream accepts the word when high with DOUT_VLD.
REQ-012 SHALL have port ERR  out  1  sticky error flag.

Function
REQ-013 SHALL capture FIFO_DATA into the skid buffer on each cycle FIFO_VF=1, which is the cycle after FIFO_RD_EN=1 (read latency 1).
REQ-014 SHALL count occupancy 0..2 plus in-flight 0..1, and assert FIFO_RD_EN only when (occupancy + in-flight - pop_this_cycle) < 2; the buffer never overflows.
REQ-015 SHALL use FSM states IDLE, STREAM, SINGLE and WAIT.
REQ-016 IDLE: FIFO_RD_EN=0; go to STREAM if ENABLE & !FIFO_EF & !FIFO_AEF; go to SINGLE if ENABLE & !FIFO_EF & FIFO_AEF.
REQ-017 STREAM: back-to-back reads allowed under credit; on FIFO_AEF=1 go to SINGLE; on ENABLE=0 go to IDLE.
REQ-018 SINGLE: issue exactly one read, then go to WAIT.
REQ-019 WAIT: no read for one cycle so the FIFO_EF and FIFO_AEF flags reflect the pop; then go to IDLE.
REQ-020 SHALL finish an in-flight read after ENABLE falls; the returned word is still buffered and delivered.
REQ-021 SHALL keep DOUT/DOUT_VLD stable while DOUT_VLD=1 & DOUT_RDY=0, and deliver words in FIFO order.
REQ-022 On simultaneous capture and pop, occupancy SHALL be unchanged; pass-through latency from FIFO_RD_EN to DOUT_VLD is 2 cycles.
REQ-023 SHALL set ERR on FIFO_UF=1, or on FIFO_VF=1 with no read in flight; ERR holds until reset.

Reset
REQ-024 RST_N=0 SHALL asynchronously force state IDLE, FIFO_RD_EN=0, DOUT_VLD=0, DOUT=0, ERR=0, occupancy=0, in-flight=0.
REQ-025 Reset mid-operation SHALL discard buffered and in-flight words; a FIFO_VF after reset release with no read in flight is ignored and does not set ERR.

Configuration
REQ-026 Macro FIFO_READER_STATS_EN defined: adds output WORD_CNT, 16 bits, counting DOUT handshakes, wrapping 65535->0, reset to 0.
REQ-027 FIFO_READER_STATS_EN undefined: the WORD_CNT port and its logic are absent.

Structure
REQ-028 Package fifo_reader_pkg SHALL hold the DATA_W default, SKID_DEPTH and the FSM state typedef (IDLE, STREAM, SINGLE, WAIT).
REQ-029 The 2-entry buffer SHALL be the sub-module fifo_reader_skid (push/pop/occupancy); the FSM and credit logic live in fifo_reader.

Verification
REQ-030 Full FIFO, 32 words 1..32, with ENABLE=1 and DOUT_RDY=1 -> DOUT yields 1..32 in order, one word per cycle in STREAM, then SINGLE/WAIT spacing near empty; ERR=0.
REQ-031 DOUT_RDY=0 for 10 cycles mid-stream -> FIFO_RD_EN drops after the buffer holds 2 words, DOUT stays stable, no word is lost or duplicated.
REQ-032 FIFO with 1 word (AEF=1) -> exactly one FIFO_RD_EN pulse, the WAIT cycle is observed, the state returns to IDLE, and FIFO_EF stops further reads.
REQ-033 ENABLE falls in the cycle FIFO_RD_EN=1 -> that word still appears on DOUT, and no further reads are issued.
REQ-034 RST_N pulsed low while 2 words are buffered -> DOUT_VLD=0 immediately; after release, the next word delivered is the next FIFO word; ERR=0.
REQ-035 Inject FIFO_UF=1 -> ERR=1, and it persists until RST_N; with FIFO_READER_STATS_EN defined, WORD_CNT equals the number of handshakes (e.g. 32 after REQ-030).
